// File: rtl/rvfi_seq_pkg.sv
// Shared widths and the rvfi_pkt field layout for the RVFI channel sequencer.
// The layout is a function of XLEN, so widths/offsets are exposed as functions.
package rvfi_seq_pkg;

  localparam int ORDW       = 8;
  localparam int INSN_OFF   = 0;
  localparam int INSN_W     = 32;
  localparam int TRAP_OFF   = 32;
  localparam int RS1_OFF    = 33;
  localparam int RS2_OFF    = 38;
  localparam int RD_OFF     = 43;
  localparam int REG_W      = 5;
  localparam int XFIELD_OFF = 48;

  // XLEN-wide fields follow the fixed header in this order, then rmask, wmask.
  typedef enum logic [3:0] {
    XF_PC_RDATA, XF_PC_WDATA, XF_RS1_RDATA, XF_RS2_RDATA,
    XF_RD_WDATA, XF_MEM_ADDR, XF_MEM_RDATA, XF_MEM_WDATA, XF_COUNT
  } xfield_e;

  function automatic int xfield_off(int xlen, xfield_e f);
    return XFIELD_OFF + int'(f) * xlen;
  endfunction

  function automatic int mask_off(int xlen, bit wmask);
    return XFIELD_OFF + int'(XF_COUNT) * xlen + (wmask ? xlen / 8 : 0);
  endfunction

  function automatic int pkt_w(int xlen);
    return XFIELD_OFF + int'(XF_COUNT) * xlen + 2 * (xlen / 8);
  endfunction

endpackage

// File: rtl/rvfi_seq_fifo.sv
// Multi-write (up to NWR consecutive slots per cycle), single-read FIFO with count.
// Head data comes straight from the storage array; empty FIFO presents zero.
module rvfi_seq_fifo #(
  parameter  int W     = 8,
  parameter  int NWR   = 2,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1,
  localparam int NW    = $clog2(NWR + 1)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic [NW-1:0] push_n,
  input  logic [W-1:0]  push_data [NWR],
  input  logic          pop,
  output logic          head_valid,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          pop_eff;

  assign pop_eff = pop && head_valid;

  // Storage is not reset; count gates what is visible.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NWR; k++) begin
      if (k < int'(push_n)) mem[wr_ptr_reg + AW'(k)] <= push_data[k];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push_n);
      if (pop_eff) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg  <= count_reg + CW'(push_n) - CW'(pop_eff);
    end
  end

  assign head_valid = (count_reg != '0);
  assign head_data  = head_valid ? mem[rd_ptr_reg] : '0;
  assign count      = count_reg;

endmodule

// File: rtl/rvfi_channel_sequencer.sv
// Serialises NRET-wide RVFI retirements into one in-order stream via a FIFO.
// Define RVFI_SEQ_ORDER_CHECK_EN to enable rvfi_order continuity checking.
module rvfi_channel_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter  int NRET  = 2,
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 8,
  localparam int PKTW  = pkt_w(XLEN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [NRET*ORDW-1:0] rvfi_order,
  input  logic [NRET*PKTW-1:0] rvfi_pkt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ORDW-1:0]      out_order,
  output logic [PKTW-1:0]      out_pkt,
  output logic                 overflow,
  output logic                 order_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(NRET + 1);
  localparam int EW = ORDW + PKTW;

  logic [NW-1:0] rank [NRET];
  logic [NW-1:0] grp_n;
  logic [EW-1:0] grp_data [NRET];
  logic [NW-1:0] push_n;
  logic [CW-1:0] count;
  logic [CW:0]   free_slots;
  logic [EW-1:0] head_data;
  logic          pop;
  logic          accept;
  logic          drop;
  logic          overflow_reg;

  // rank[i] = number of valid channels below i, i.e. the compacted slot of channel i.
  always_comb begin
    grp_n = '0;
    for (int i = 0; i < NRET; i++) begin
      rank[i] = grp_n;
      grp_n   = grp_n + NW'(rvfi_valid[i]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRET; gi++) begin : g_slot
      always_comb begin
        grp_data[gi] = '0;
        for (int i = 0; i < NRET; i++) begin
          if (rvfi_valid[i] && rank[i] == NW'(gi))
            grp_data[gi] = {rvfi_order[i*ORDW +: ORDW], rvfi_pkt[i*PKTW +: PKTW]};
        end
      end
    end
  endgenerate

  assign pop        = out_valid && out_ready;
  assign free_slots = (CW+1)'(DEPTH) - (CW+1)'(count) + (CW+1)'(pop);
  assign accept     = enable && (grp_n != '0) && ((CW+1)'(grp_n) <= free_slots);
  assign drop       = enable && (grp_n != '0) && !accept;
  assign push_n     = accept ? grp_n : '0;

  rvfi_seq_fifo #(
    .W    (EW),
    .NWR  (NRET),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .srst      (reset),
    .push_n    (push_n),
    .push_data (grp_data),
    .pop       (pop),
    .head_valid(out_valid),
    .head_data (head_data),
    .count     (count)
  );

  assign out_order = head_data[EW-1 -: ORDW];
  assign out_pkt   = head_data[PKTW-1:0];

  // Whole group is discarded on overflow, never a partial write.
  always_ff @(posedge clk) begin
    if (reset)     overflow_reg <= 1'b0;
    else if (drop) overflow_reg <= 1'b1;
  end
  assign overflow = overflow_reg;

`ifdef RVFI_SEQ_ORDER_CHECK_EN
  logic [ORDW-1:0] expect_order_reg;
  logic [ORDW-1:0] last_order;
  logic            expect_init_reg;
  logic            order_err_reg;
  logic            mismatch;

  always_comb begin
    last_order = '0;
    mismatch   = 1'b0;
    for (int s = 0; s < NRET; s++) begin
      if (NW'(s) < grp_n) begin
        last_order = grp_data[s][EW-1 -: ORDW];
        if (last_order != expect_order_reg + ORDW'(s)) mismatch = 1'b1;
      end
    end
  end

  // expect_order follows the last accepted entry, so one bad order flags once and resyncs.
  always_ff @(posedge clk) begin
    if (reset) begin
      expect_order_reg <= '0;
      expect_init_reg  <= 1'b0;
      order_err_reg    <= 1'b0;
    end else if (accept) begin
      expect_order_reg <= last_order + ORDW'(1);
      expect_init_reg  <= 1'b1;
      if (expect_init_reg && mismatch) order_err_reg <= 1'b1;
    end
  end
  assign order_err = order_err_reg;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_channel_sequencer.sv
// Directed bench for rvfi_channel_sequencer (NRET=2, XLEN=32, DEPTH=8).
module tb_rvfi_channel_sequencer;
  import rvfi_seq_pkg::*;

  localparam int NRET  = 2;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int PKTW  = pkt_w(XLEN);
`ifdef RVFI_SEQ_ORDER_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [NRET-1:0]      rvfi_valid;
  logic [NRET*ORDW-1:0] rvfi_order;
  logic [NRET*PKTW-1:0] rvfi_pkt;
  logic                 out_valid;
  logic                 out_ready;
  logic [ORDW-1:0]      out_order;
  logic [PKTW-1:0]      out_pkt;
  logic                 overflow;
  logic                 order_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rvfi_channel_sequencer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order),
    .rvfi_pkt  (rvfi_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_order (out_order),
    .out_pkt   (out_pkt),
    .overflow  (overflow),
    .order_err (order_err)
  );

  function automatic logic [PKTW-1:0] mk_pkt(input logic [7:0] o);
    logic [PKTW-1:0] p;
    p = '0;
    p[31:0]        = {24'hC0FFEE, o};
    p[100 +: 8]    = o ^ 8'h5A;
    p[PKTW-1 -: 8] = ~o;
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] o0, input logic [7:0] o1,
                       input logic rdy);
    rvfi_valid = v;
    rvfi_order = {o1, o0};
    rvfi_pkt   = {mk_pkt(o1), mk_pkt(o0)};
    out_ready  = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(2'b00, 8'd0, 8'd0, rdy);
  endtask

  task automatic expect_head(input string tag, input logic [7:0] o);
    check($sformatf("%s.valid", tag), 64'(out_valid), 64'd1);
    check($sformatf("%s.order", tag), 64'(out_order), 64'(o));
    check($sformatf("%s.pkt", tag), 64'(out_pkt == mk_pkt(o)), 64'd1);
    $display("txn %s head order=%0d valid=%0b", tag, out_order, out_valid);
  endtask

  task automatic expect_empty(input string tag);
    check($sformatf("%s.empty", tag), 64'(out_valid), 64'd0);
    $display("txn %s empty valid=%0b", tag, out_valid);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b1;
    idle(1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.order", 64'(out_order), 64'd0);
    check("rst.pkt_zero", 64'(out_pkt == '0), 64'd1);
    check("rst.overflow", 64'(overflow), 64'd0);
    check("rst.order_err", 64'(order_err), 64'd0);

    // 1: single retire per cycle, one-cycle lag
    for (int k = 0; k < 10; k++) begin
      drive(2'b01, 8'(k), 8'd0, 1'b1);
      tick();
      expect_head($sformatf("t1.%0d", k), 8'(k));
    end
    idle(1'b1);
    tick();
    expect_empty("t1.end");
    check("t1.overflow", 64'(overflow), 64'd0);
    check("t1.order_err", 64'(order_err), 64'd0);

    // 2: both channels back-to-back
    do_reset();
    drive(2'b11, 8'd4, 8'd5, 1'b1);
    tick();
    expect_head("t2.a", 8'd4);
    drive(2'b11, 8'd6, 8'd7, 1'b1);
    tick();
    expect_head("t2.b", 8'd5);
    idle(1'b1);
    tick();
    expect_head("t2.c", 8'd6);
    tick();
    expect_head("t2.d", 8'd7);
    tick();
    expect_empty("t2.end");
    check("t2.order_err", 64'(order_err), 64'd0);

    // 3: fill, then overflowing group dropped whole
    do_reset();
    for (int g = 0; g < 4; g++) begin
      drive(2'b11, 8'(2*g), 8'(2*g+1), 1'b0);
      tick();
      check($sformatf("t3.fill%0d.overflow", g), 64'(overflow), 64'd0);
    end
    drive(2'b11, 8'd8, 8'd9, 1'b0);
    tick();
    check("t3.overflow", 64'(overflow), 64'd1);
    idle(1'b1);
    for (int k = 0; k < 8; k++) begin
      expect_head($sformatf("t3.drain%0d", k), 8'(k));
      tick();
    end
    expect_empty("t3.end");
    check("t3.overflow_sticky", 64'(overflow), 64'd1);
    check("t3.order_err", 64'(order_err), 64'd0);

    // 4: full FIFO with pop accepts n=1, rejects n=2
    do_reset();
    for (int g = 0; g < 4; g++) begin
      drive(2'b11, 8'(2*g), 8'(2*g+1), 1'b0);
      tick();
    end
    drive(2'b01, 8'd8, 8'd0, 1'b1);
    tick();
    check("t4.push8.overflow", 64'(overflow), 64'd0);
    expect_head("t4.push8", 8'd1);
    drive(2'b01, 8'd9, 8'd0, 1'b1);
    tick();
    check("t4.push9.overflow", 64'(overflow), 64'd0);
    expect_head("t4.push9", 8'd2);
    drive(2'b11, 8'd10, 8'd11, 1'b1);
    tick();
    check("t4.pair.overflow", 64'(overflow), 64'd1);
    expect_head("t4.pair", 8'd3);
    idle(1'b1);
    for (int k = 3; k < 10; k++) begin
      expect_head($sformatf("t4.drain%0d", k), 8'(k));
      tick();
    end
    expect_empty("t4.end");
    check("t4.order_err", 64'(order_err), 64'd0);

    // 5: order wrap is legal, a jump is flagged and sticky
    do_reset();
    drive(2'b01, 8'd254, 8'd0, 1'b1);
    tick();
    expect_head("t5.254", 8'd254);
    check("t5.254.err", 64'(order_err), 64'd0);
    drive(2'b01, 8'd255, 8'd0, 1'b1);
    tick();
    expect_head("t5.255", 8'd255);
    check("t5.255.err", 64'(order_err), 64'd0);
    drive(2'b01, 8'd0, 8'd0, 1'b1);
    tick();
    expect_head("t5.0", 8'd0);
    check("t5.0.err", 64'(order_err), 64'd0);
    drive(2'b01, 8'd3, 8'd0, 1'b1);
    tick();
    expect_head("t5.3", 8'd3);
    check("t5.3.err", 64'(order_err), 64'(ERR_EXP));
    drive(2'b01, 8'd4, 8'd0, 1'b1);
    tick();
    expect_head("t5.4", 8'd4);
    check("t5.4.err", 64'(order_err), 64'(ERR_EXP));
    idle(1'b1);
    tick();
    expect_empty("t5.end");

    // 6: gapped valid compaction, reset mid-stream, enable low
    do_reset();
    drive(2'b10, 8'd77, 8'd9, 1'b1);
    tick();
    expect_head("t6.9", 8'd9);
    check("t6.9.err", 64'(order_err), 64'd0);
    drive(2'b01, 8'd10, 8'd0, 1'b1);
    tick();
    expect_head("t6.10", 8'd10);
    check("t6.10.err", 64'(order_err), 64'd0);
    drive(2'b11, 8'd11, 8'd50, 1'b0);
    tick();
    expect_head("t6.hold", 8'd10);
    check("t6.50.err", 64'(order_err), 64'(ERR_EXP));
    reset = 1'b1;
    idle(1'b0);
    tick();
    expect_empty("t6.rst");
    check("t6.rst.order", 64'(out_order), 64'd0);
    check("t6.rst.err", 64'(order_err), 64'd0);
    check("t6.rst.overflow", 64'(overflow), 64'd0);
    reset  = 1'b0;
    enable = 1'b0;
    drive(2'b11, 8'd1, 8'd2, 1'b1);
    tick();
    expect_empty("t6.disabled");
    enable = 1'b1;
    idle(1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
